// File: rtl/seq_divider8.sv
// Iterative restoring unsigned divider: one quotient bit per clock, using an
// 8-bit parallel-prefix adder as the trial subtractor (R - D = R + ~D + 1).

module Prefix_Add8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       cIn,
  output logic [7:0] sum,
  output logic       cOut
);

  logic [7:0] g0, p0, g1, p1, g2, p2, g3;

  // Kogge-Stone: after three levels g3[i] is the carry out of bits i..0,
  // with the carry-in folded into bit 0's generate.
  always_comb begin
    g0 = x & y;
    p0 = x ^ y;
    g0[0] = g0[0] | (p0[0] & cIn);

    g1 = g0;
    p1 = p0;
    for (int i = 1; i < 8; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
      p1[i] = p0[i] & p0[i-1];
    end

    g2 = g1;
    p2 = p1;
    for (int i = 2; i < 8; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end

    g3 = g2;
    for (int i = 4; i < 8; i++) begin
      g3[i] = g2[i] | (p2[i] & g2[i-4]);
    end
  end

  assign sum  = p0 ^ {g3[6:0], cIn};
  assign cOut = g3[7];

endmodule

module seq_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, nextState;
  logic [WIDTH-1:0] qReg, dReg, rReg;
  logic [CNT_W-1:0] cnt;

  logic             accept, dbzAccept, finish;
  logic [WIDTH-1:0] rShift, dInv, diff, rNext, qNext;
  logic             msb, cOut, take;

  assign msb    = rReg[WIDTH-1];
  assign rShift = {rReg[WIDTH-2:0], qReg[WIDTH-1]};
  assign dInv   = ~dReg;

  Prefix_Add8 uSub (
    .x    (rShift),
    .y    (dInv),
    .cIn  (1'b1),
    .sum  (diff),
    .cOut (cOut)
  );

  // A set msb means the 9-bit shifted remainder is >= 256 > D, so the
  // subtraction must succeed even though the adder sees only 8 bits.
  assign take  = msb | cOut;
  assign rNext = take ? diff : rShift;
  assign qNext = {qReg[WIDTH-2:0], take};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    dbzAccept = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            accept    = 1'b1;
            nextState = RUN;
          end else begin
            dbzAccept = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt == CNT_W'(1)) begin
          finish    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      qReg      <= '0;
      dReg      <= '0;
      rReg      <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        qReg      <= dividend;
        dReg      <= divisor;
        rReg      <= '0;
        cnt       <= CNT_W'(WIDTH);
        divByZero <= 1'b0;
      end else if (dbzAccept) begin
        quotient  <= '1;
        remainder <= dividend;
        divByZero <= 1'b1;
        done      <= 1'b1;
      end else if (state == RUN) begin
        qReg <= qNext;
        rReg <= rNext;
        cnt  <= cnt - CNT_W'(1);
        if (finish) begin
          quotient  <= qNext;
          remainder <= rNext;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule
